// File: rtl/lsu_proto_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_proto_pkg
//  Description : Shared constants and types for the byte-serial load/store
//                protocol. Used by the load/store unit and the memory-side
//                responder.
//  Revision    : 1.0  initial release
// ============================================================================
package lsu_proto_pkg;

  // Flag bytes that open a command frame
  localparam logic [7:0] FLAG_LOAD  = 8'h01;
  localparam logic [7:0] FLAG_STORE = 8'h02;

  // Words travel over the link most-significant byte first
  localparam bit HIGH_BYTE_FIRST = 1'b1;

  // Responder state encoding
  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_ADDR = 4'd1,
    ST_GET_DH   = 4'd2,
    ST_GET_DL   = 4'd3,
    ST_WRITE    = 4'd4,
    ST_READ     = 4'd5,
    ST_SEND_H   = 4'd6,
    ST_GAP_H    = 4'd7,
    ST_SEND_L   = 4'd8
  } resp_state_t;

endpackage
`default_nettype wire

// File: rtl/resp_mem.sv
`default_nettype none
// ============================================================================
//  Module      : resp_mem
//  Description : 2**ADDR_W x DATA_W word memory, one synchronous write port
//                and one synchronous read port with 1-cycle latency.
//                Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
module resp_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port; read data holds when re is low
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/uart_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_mem_responder
//  Description : Memory-side end of the UART load/store protocol. Decodes
//                flag/address/data bytes, performs the access on resp_mem
//                and returns load data as two bytes over the UART.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_mem_responder #(
  parameter int          ADDR_W         = 8,
  parameter int          DATA_W         = 16,
  parameter int          TIMEOUT_CYCLES = 100000,
  parameter logic [7:0]  FLAG_LOAD      = lsu_proto_pkg::FLAG_LOAD,
  parameter logic [7:0]  FLAG_STORE     = lsu_proto_pkg::FLAG_STORE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_do,
  input  logic [7:0] rx_data,
  input  logic       tx_done,
  output logic       tx_start_out,
  output logic [7:0] tx_data_out,
  output logic       busy_out,
  output logic       err_out,
  output logic       access_done_out
);

  import lsu_proto_pkg::*;

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  resp_state_t       r_state;
  logic              r_is_load;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_in_get;
  logic              w_no_rx;
  logic              w_expired;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;
  logic [7:0]        w_first_byte;
  logic [7:0]        w_second_byte;

  assign w_in_get  = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DH) ||
                     (r_state == ST_GET_DL);
  // States in which an incoming byte has nowhere to go
  assign w_no_rx   = (r_state == ST_WRITE)  || (r_state == ST_READ)  ||
                     (r_state == ST_SEND_H) || (r_state == ST_GAP_H) ||
                     (r_state == ST_SEND_L);
  assign w_expired = w_in_get && !rx_do && (r_cnt == CNT_MAX);
  assign w_we      = (r_state == ST_WRITE);
  assign w_re      = (r_state == ST_READ);
  assign busy_out  = (r_state != ST_IDLE);

  assign w_first_byte  = HIGH_BYTE_FIRST ? w_rdata[DATA_W-1 -: 8] : w_rdata[7:0];
  assign w_second_byte = HIGH_BYTE_FIRST ? w_rdata[7:0] : w_rdata[DATA_W-1 -: 8];

  resp_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_addr),
    .wdata (r_wdata),
    .re    (w_re),
    .raddr (r_addr),
    .rdata (w_rdata)
  );

  // Byte to transmit is driven only while a SEND state owns the UART
  always_comb begin
    tx_data_out = 8'h00;
    case (r_state)
      ST_SEND_H: tx_data_out = w_first_byte;
      ST_SEND_L: tx_data_out = w_second_byte;
      default:   tx_data_out = 8'h00;
    endcase
  end

  // Frame decode, access sequencing, inter-byte timeout and pulse outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_is_load       <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_cnt           <= '0;
      tx_start_out    <= 1'b1;
      err_out         <= 1'b0;
      access_done_out <= 1'b0;
    end else begin
      err_out         <= 1'b0;
      access_done_out <= 1'b0;
      tx_start_out    <= 1'b1;

      // Idle-clock counter: only between bytes of a frame, cleared by any byte
      if (w_in_get && !rx_do && !w_expired) r_cnt <= r_cnt + CNT_W'(1);
      else                                  r_cnt <= '0;

      case (r_state)
        ST_IDLE: begin
          if (rx_do) begin
            if (rx_data == FLAG_LOAD || rx_data == FLAG_STORE) begin
              r_is_load <= (rx_data == FLAG_LOAD);
              r_state   <= ST_GET_ADDR;
            end else begin
              err_out <= 1'b1;
            end
          end
        end
        ST_GET_ADDR: begin
          if (rx_do) begin
            r_addr  <= rx_data[ADDR_W-1:0];
            r_state <= r_is_load ? ST_READ : ST_GET_DH;
          end
        end
        ST_GET_DH: begin
          if (rx_do) begin
            r_wdata[DATA_W-1 -: 8] <= rx_data;
            r_state                <= ST_GET_DL;
          end
        end
        ST_GET_DL: begin
          if (rx_do) begin
            r_wdata[7:0] <= rx_data;
            r_state      <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          access_done_out <= 1'b1;
          r_state         <= ST_IDLE;
        end
        ST_READ: begin
          tx_start_out <= 1'b0;
          r_state      <= ST_SEND_H;
        end
        ST_SEND_H: begin
          if (tx_done) r_state      <= ST_GAP_H;
          else         tx_start_out <= 1'b0;
        end
        ST_GAP_H: begin
          tx_start_out <= 1'b0;
          r_state      <= ST_SEND_L;
        end
        ST_SEND_L: begin
          if (tx_done) begin
            access_done_out <= 1'b1;
            r_state         <= ST_IDLE;
          end else begin
            tx_start_out <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Abandon a stalled frame; nothing was written yet
      if (w_expired) begin
        err_out <= 1'b1;
        r_state <= ST_IDLE;
      end

      // A byte arriving while busy with an access is dropped
      if (rx_do && w_no_rx) err_out <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_mem_responder
//  Description : Scoreboard bench for uart_mem_responder. Stimulus pushes
//                expected tx bytes / err / done events; a monitor pops them
//                as the DUT produces them. A small UART model answers
//                tx_start_out with tx_done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_mem_responder;

  localparam int T_OUT = 40;

  logic       clk;
  logic       rst_n;
  logic       rx_do;
  logic [7:0] rx_data;
  logic       tx_done;
  logic       tx_start_out;
  logic [7:0] tx_data_out;
  logic       busy_out;
  logic       err_out;
  logic       access_done_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] q_tx[$];
  bit         q_err[$];
  bit         q_done[$];

  uart_mem_responder #(
    .ADDR_W         (8),
    .DATA_W         (16),
    .TIMEOUT_CYCLES (T_OUT),
    .FLAG_LOAD      (8'h01),
    .FLAG_STORE     (8'h02)
  ) dut (
    .clk             (clk),
    .reset           (rst_n),
    .rx_do           (rx_do),
    .rx_data         (rx_data),
    .tx_done         (tx_done),
    .tx_start_out    (tx_start_out),
    .tx_data_out     (tx_data_out),
    .busy_out        (busy_out),
    .err_out         (err_out),
    .access_done_out (access_done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // UART transmitter model: finishes a byte 4 cycles after start goes low
  initial begin
    int tcnt;
    tcnt    = 0;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst_n && !tx_start_out) begin
        tcnt++;
        if (tcnt == 4) begin
          tx_done = 1'b1;
          tcnt    = 0;
        end
      end else begin
        tcnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event
  initial begin
    bit         prev_start;
    bit         second;
    int         hi_cnt;
    logic [7:0] exp_b;
    prev_start = 1'b1;
    second     = 1'b0;
    hi_cnt     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_start = 1'b1;
        second     = 1'b0;
        hi_cnt     = 0;
      end else begin
        if (err_out) begin
          check(q_err.size() != 0, "err_pulse_expected", 1, 0);
          if (q_err.size() != 0) void'(q_err.pop_front());
        end
        if (access_done_out) begin
          check(q_done.size() != 0, "done_pulse_expected", 1, 0);
          if (q_done.size() != 0) void'(q_done.pop_front());
        end
        if (!tx_start_out && prev_start) begin
          if (q_tx.size() == 0) begin
            check(1'b0, "tx_byte_unexpected", int'(tx_data_out), 0);
          end else begin
            exp_b = q_tx.pop_front();
            check(tx_data_out == exp_b, "tx_byte", int'(tx_data_out), int'(exp_b));
          end
          if (second) check(hi_cnt == 1, "tx_gap_cycles", hi_cnt, 1);
          second = !second;
        end
        if (tx_start_out && second)
          check(tx_data_out == 8'h00, "gap_data_zero", int'(tx_data_out), 0);
        if (tx_start_out) hi_cnt++;
        else              hi_cnt = 0;
        prev_start = tx_start_out;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_do   = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_do   = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy_out) return;
      @(negedge clk);
    end
    check(1'b0, "wait_idle_timeout", 1, 0);
  endtask

  task automatic do_store(input logic [7:0] a, input logic [15:0] d);
    q_done.push_back(1'b1);
    send_byte(8'h02);
    send_byte(a);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
    wait_idle();
  endtask

  task automatic do_load(input logic [7:0] a, input logic [15:0] d, input bit chk_lat);
    q_tx.push_back(d[15:8]);
    q_tx.push_back(d[7:0]);
    q_done.push_back(1'b1);
    send_byte(8'h01);
    send_byte(a);
    if (chk_lat) begin
      check(tx_start_out == 1'b1, "load_latency_pre", int'(tx_start_out), 1);
      @(negedge clk);
      check(tx_start_out == 1'b0, "load_latency_fall", int'(tx_start_out), 0);
    end
    wait_idle();
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_do   = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check(busy_out == 1'b0,        "reset_busy",     int'(busy_out), 0);
    check(tx_start_out == 1'b1,    "reset_tx_start", int'(tx_start_out), 1);
    check(tx_data_out == 8'h00,    "reset_tx_data",  int'(tx_data_out), 0);
    check(err_out == 1'b0,         "reset_err",      int'(err_out), 0);
    check(access_done_out == 1'b0, "reset_done",     int'(access_done_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Store then load with latency check
    do_store(8'h3C, 16'hBEEF);
    do_load(8'h3C, 16'hBEEF, 1'b1);

    // Bad flag, then a valid frame is still accepted
    q_err.push_back(1'b1);
    send_byte(8'h03);
    check(busy_out == 1'b0, "badflag_busy", int'(busy_out), 0);
    do_store(8'h00, 16'h1234);
    do_load(8'h00, 16'h1234, 1'b0);

    // Timeout after the high data byte: frame dropped, old contents kept
    do_store(8'h10, 16'h5A5A);
    q_err.push_back(1'b1);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'hAA);
    repeat (T_OUT - 1) @(negedge clk);
    check(busy_out == 1'b1, "timeout_not_early", int'(busy_out), 1);
    @(negedge clk);
    check(busy_out == 1'b0, "timeout_idle", int'(busy_out), 0);
    do_load(8'h10, 16'h5A5A, 1'b0);

    // Address extremes back to back
    do_store(8'h00, 16'h0001);
    do_store(8'hFF, 16'hFFFE);
    do_load(8'h00, 16'h0001, 1'b0);
    do_load(8'hFF, 16'hFFFE, 1'b0);

    // Overrun during SEND_H of a load of 0xFF
    q_tx.push_back(8'hFF);
    q_tx.push_back(8'hFE);
    q_done.push_back(1'b1);
    q_err.push_back(1'b1);
    send_byte(8'h01);
    send_byte(8'hFF);
    begin
      int k;
      k = 0;
      while (tx_start_out && k < 50) begin
        @(negedge clk);
        k++;
      end
      check(tx_start_out == 1'b0, "overrun_send_seen", int'(tx_start_out), 0);
    end
    send_byte(8'h55);
    wait_idle();

    // Reset in the middle of a store leaves memory untouched
    do_store(8'h20, 16'hCAFE);
    send_byte(8'h02);
    send_byte(8'h20);
    send_byte(8'h11);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check(busy_out == 1'b0,     "midreset_busy",     int'(busy_out), 0);
    check(tx_start_out == 1'b1, "midreset_tx_start", int'(tx_start_out), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_load(8'h20, 16'hCAFE, 1'b0);

    repeat (10) @(negedge clk);
    check(q_tx.size() == 0,   "tx_queue_drained",   q_tx.size(), 0);
    check(q_err.size() == 0,  "err_queue_drained",  q_err.size(), 0);
    check(q_done.size() == 0, "done_queue_drained", q_done.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
